// File: rtl/store_step_counter_pkg.sv
// Shared constants for the store_step_counter bank: overflow-mode encoding and step reset.
package store_step_counter_pkg;

    localparam int unsigned MODE_WRAP          = 0;
    localparam int unsigned MODE_SATURATE      = 1;
    localparam int unsigned STEP_RESET_DEFAULT = 3;

endpackage

// File: rtl/store_step_channel.sv
// One accumulator channel: a store plus sticky overflow/underflow flags, updated by a
// shared step on the falling clock edge.
module store_step_channel
    import store_step_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned SATURATE = MODE_WRAP
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             inc,
    input  logic             dec,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] step,
    input  logic             flag_clr,
    output logic [WIDTH-1:0] store,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] store_q, store_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf_event, unf_event;

    assign sum    = {1'b0, store_q} + {1'b0, step};
    assign diff   = store_q - step;
    assign borrow = step > store_q;

    always_comb begin
        store_d   = store_q;
        ovf_event = 1'b0;
        unf_event = 1'b0;
        if (load) begin
            store_d = load_value;
        end else if (inc && !dec) begin
            ovf_event = sum[WIDTH];
            store_d   = (SATURATE == MODE_SATURATE && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
        end else if (dec && !inc) begin
            unf_event = borrow;
            store_d   = (SATURATE == MODE_SATURATE && borrow) ? '0 : diff;
        end
        // A new event wins over a same-edge clear.
        ovf_d = ovf_event | (ovf_q & ~flag_clr);
        unf_d = unf_event | (unf_q & ~flag_clr);
    end

    always_ff @(negedge clock or negedge clear_n) begin
        if (!clear_n) begin
            store_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            store_q <= store_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign store     = store_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: rtl/store_step_counter.sv
// Bank of CHANNELS independent step accumulators sharing one programmable step register.
module store_step_counter
    import store_step_counter_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned STEP_RESET = STEP_RESET_DEFAULT,
    parameter int unsigned SATURATE   = MODE_WRAP
) (
    input  logic                      clock,
    input  logic                      clear_n,
    input  logic [CHANNELS-1:0]       inc,
    input  logic [CHANNELS-1:0]       dec,
    input  logic [CHANNELS-1:0]       load,
    input  logic [WIDTH-1:0]          load_value,
    input  logic                      step_wr,
    input  logic [WIDTH-1:0]          step_value,
    input  logic [CHANNELS-1:0]       flag_clr,
    output logic [CHANNELS*WIDTH-1:0] store,
    output logic [WIDTH-1:0]          step,
    output logic [CHANNELS-1:0]       overflow,
    output logic [CHANNELS-1:0]       underflow
);

    logic [WIDTH-1:0] step_q, step_d;

    always_comb begin
        step_d = step_q;
        if (step_wr) begin
            step_d = step_value;
        end
    end

    // Channels see step_q, so a same-edge step write only takes effect on the next edge.
    always_ff @(negedge clock or negedge clear_n) begin
        if (!clear_n) begin
            step_q <= WIDTH'(STEP_RESET);
        end else begin
            step_q <= step_d;
        end
    end

    assign step = step_q;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        store_step_channel #(
            .WIDTH    (WIDTH),
            .SATURATE (SATURATE)
        ) u_chan (
            .clock      (clock),
            .clear_n    (clear_n),
            .inc        (inc[k]),
            .dec        (dec[k]),
            .load       (load[k]),
            .load_value (load_value),
            .step       (step_q),
            .flag_clr   (flag_clr[k]),
            .store      (store[k*WIDTH +: WIDTH]),
            .overflow   (overflow[k]),
            .underflow  (underflow[k])
        );
    end

endmodule

// File: tb/tb_store_step_counter.sv
// Scoreboard bench for store_step_counter: 32-bit wrap, 8-bit wrap and 8-bit saturate instances.
module tb_store_step_counter;

    logic clock = 1'b1;
    logic clear_n;
    always #5 clock = ~clock;

    // 32-bit, 4-channel, wrap
    logic [3:0]   inc32, dec32, load32, fclr32, ov32, un32;
    logic [31:0]  lv32, stepv32, st32;
    logic         stepwr32;
    logic [127:0] s32;
    // 8-bit, 2-channel, wrap
    logic [1:0]   incw, decw, loadw, fclrw, ovw, unw;
    logic [7:0]   lvw, stepvw, stw;
    logic         stepwrw;
    logic [15:0]  sw;
    // 8-bit, 2-channel, saturate
    logic [1:0]   incs, decs, loads, fclrs, ovs, uns;
    logic [7:0]   lvs, stepvs, sts;
    logic         stepwrs;
    logic [15:0]  ss;

    store_step_counter #(.WIDTH(32), .CHANNELS(4), .STEP_RESET(3), .SATURATE(0)) u_dut32 (
        .clock(clock), .clear_n(clear_n), .inc(inc32), .dec(dec32), .load(load32),
        .load_value(lv32), .step_wr(stepwr32), .step_value(stepv32), .flag_clr(fclr32),
        .store(s32), .step(st32), .overflow(ov32), .underflow(un32)
    );
    store_step_counter #(.WIDTH(8), .CHANNELS(2), .STEP_RESET(3), .SATURATE(0)) u_dutw (
        .clock(clock), .clear_n(clear_n), .inc(incw), .dec(decw), .load(loadw),
        .load_value(lvw), .step_wr(stepwrw), .step_value(stepvw), .flag_clr(fclrw),
        .store(sw), .step(stw), .overflow(ovw), .underflow(unw)
    );
    store_step_counter #(.WIDTH(8), .CHANNELS(2), .STEP_RESET(3), .SATURATE(1)) u_duts (
        .clock(clock), .clear_n(clear_n), .inc(incs), .dec(decs), .load(loads),
        .load_value(lvs), .step_wr(stepwrs), .step_value(stepvs), .flag_clr(fclrs),
        .store(ss), .step(sts), .overflow(ovs), .underflow(uns)
    );

    // Observation selectors
    localparam int S32 = 0, STEP32 = 4, OV32 = 5, UN32 = 6;
    localparam int SW = 10, STEPW = 12, OVW = 13, UNW = 14;
    localparam int SS = 20, STEPS = 22, OVS = 23, UNS = 24;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [31:0] observe(int sel);
        case (sel)
            0, 1, 2, 3: return s32[sel*32 +: 32];
            STEP32:     return st32;
            OV32:       return {28'd0, ov32};
            UN32:       return {28'd0, un32};
            10, 11:     return {24'd0, sw[(sel-SW)*8 +: 8]};
            STEPW:      return {24'd0, stw};
            OVW:        return {30'd0, ovw};
            UNW:        return {30'd0, unw};
            20, 21:     return {24'd0, ss[(sel-SS)*8 +: 8]};
            STEPS:      return {24'd0, sts};
            OVS:        return {30'd0, ovs};
            UNS:        return {30'd0, uns};
            default:    return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_val(input string tag, input int sel, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic flush();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
        flush();
    endtask

    task automatic idle();
        inc32 = '0; dec32 = '0; load32 = '0; fclr32 = '0; lv32 = '0; stepv32 = '0; stepwr32 = 0;
        incw  = '0; decw  = '0; loadw  = '0; fclrw  = '0; lvw  = '0; stepvw  = '0; stepwrw  = 0;
        incs  = '0; decs  = '0; loads  = '0; fclrs  = '0; lvs  = '0; stepvs  = '0; stepwrs  = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_n = 1'b0;
        idle();
        #10;
        for (int k = 0; k < 4; k++) expect_val("rst_store32", S32 + k, 0);
        expect_val("rst_step32", STEP32, 3);
        expect_val("rst_ov32", OV32, 0);
        expect_val("rst_un32", UN32, 0);
        expect_val("rst_stepw", STEPW, 3);
        expect_val("rst_steps", STEPS, 3);
        flush();
        clear_n = 1'b1;

        // Count by the reset step on channel 0
        inc32 = 4'b0001;
        for (int i = 1; i <= 5; i++) begin
            expect_val("inc_store0", S32, 32'(3 * i));
            tick();
        end
        inc32 = '0;
        for (int k = 1; k < 4; k++) expect_val("inc_other", S32 + k, 0);
        expect_val("inc_step", STEP32, 3);
        expect_val("inc_ov", OV32, 0);
        expect_val("inc_un", UN32, 0);
        flush();

        // Step write uses old step on the same edge
        stepwr32 = 1; stepv32 = 10; inc32 = 4'b0010;
        expect_val("stepwr_store1", S32 + 1, 3);
        expect_val("stepwr_step", STEP32, 10);
        tick();
        stepwr32 = 0;
        expect_val("newstep_store1", S32 + 1, 13);
        tick();
        inc32 = '0;

        // 8-bit wrap boundary
        loadw = 2'b01; lvw = 254;
        expect_val("w_load", SW, 254);
        tick();
        loadw = '0; incw = 2'b01;
        expect_val("w_inc_wrap", SW, 1);
        expect_val("w_ovf", OVW, 1);
        tick();
        incw = '0; decw = 2'b01;
        expect_val("w_dec_wrap", SW, 254);
        expect_val("w_unf", UNW, 1);
        expect_val("w_ovf_sticky", OVW, 1);
        tick();
        decw = '0;

        // 8-bit saturate boundary
        loads = 2'b01; lvs = 250;
        expect_val("s_load", SS, 250);
        tick();
        loads = '0; incs = 2'b01;
        expect_val("s_inc1", SS, 253);
        expect_val("s_no_ovf", OVS, 0);
        tick();
        expect_val("s_inc_clamp", SS, 255);
        expect_val("s_ovf", OVS, 1);
        tick();
        incs = '0; loads = 2'b01; lvs = 2;
        expect_val("s_load2", SS, 2);
        expect_val("s_load_keeps_flag", OVS, 1);
        tick();
        loads = '0; decs = 2'b01;
        expect_val("s_dec_clamp", SS, 0);
        expect_val("s_unf", UNS, 1);
        tick();
        decs = '0;

        // Priority: load over inc/dec, inc+dec holds
        load32 = 4'b0100; inc32 = 4'b0100; dec32 = 4'b0100; lv32 = 100;
        expect_val("prio_load", S32 + 2, 100);
        tick();
        load32 = '0;
        expect_val("prio_incdec_hold", S32 + 2, 100);
        expect_val("prio_no_flags", OV32, 0);
        tick();
        inc32 = '0; dec32 = '0;

        // Set-dominant flag clear
        loadw = 2'b10; lvw = 255;
        expect_val("w1_load", SW + 1, 255);
        tick();
        loadw = '0; incw = 2'b10; fclrw = 2'b10;
        expect_val("w1_inc", SW + 1, 2);
        expect_val("w1_set_dominant", OVW, 3);
        tick();
        incw = '0;
        expect_val("w1_clr_ovf", OVW, 1);
        expect_val("w1_clr_unf", UNW, 1);
        tick();
        fclrw = 2'b01;
        expect_val("w0_clr_ovf", OVW, 0);
        expect_val("w0_clr_unf", UNW, 0);
        tick();
        fclrw = '0;

        // Zero step: no change, no flags
        stepwrs = 1; stepvs = 0;
        expect_val("s_step0", STEPS, 0);
        tick();
        stepwrs = 0; incs = 2'b10;
        expect_val("s_step0_inc", SS + 1, 0);
        expect_val("s_step0_ovf", OVS, 1);
        tick();
        incs = '0; decs = 2'b10;
        expect_val("s_step0_dec", SS + 1, 0);
        expect_val("s_step0_unf", UNS, 1);
        tick();
        decs = '0;

        // 32-bit wrap below zero with step 10
        dec32 = 4'b1000;
        expect_val("dec32_wrap", S32 + 3, 32'hFFFF_FFF6);
        expect_val("dec32_unf", UN32, 4'b1000);
        tick();
        dec32 = '0;

        // Asynchronous reset between edges
        #2;
        clear_n = 1'b0;
        inc32 = 4'b0001;
        #1;
        for (int k = 0; k < 4; k++) expect_val("arst_store32", S32 + k, 0);
        expect_val("arst_step32", STEP32, 3);
        expect_val("arst_un32", UN32, 0);
        expect_val("arst_storew", SW, 0);
        expect_val("arst_ovw", OVW, 0);
        expect_val("arst_steps", STEPS, 3);
        flush();
        @(negedge clock);
        #1;
        expect_val("arst_hold", S32, 0);
        flush();
        clear_n = 1'b1;
        expect_val("post_rst_inc1", S32, 3);
        tick();
        expect_val("post_rst_inc2", S32, 6);
        tick();
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
